sand_gravity_stepper: RTL and testbench
=======================================

// Module: sand_gravity_stepper
// PURPOSE
//  Computes one falling-sand generation: sweeps the displayed frame (VRAM) cell by cell, applies the
//  gravity rule and writes the next state into the working RAM. Started by the game-state controller
//  via ready_i; reports completion with done_o, after which the controller copies RAM back into VRAM.
// PARAMETERS
//  ACTIVE_COLUMNS  640                                    cells per row
//  ACTIVE_ROWS     480                                    rows per frame
//  ADDR_WIDTH      $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)     linear cell address width
//  DATA_WIDTH      1                                      cell word width; bit 0 = sand, upper bits written 0
// PORTS
//  clk_i           in   1           clock
//  reset_i         in   1           asynchronous, active-high reset
//  ready_i         in   1           start request; sampled only in IDLE
//  pixel_state_i   in   DATA_WIDTH  VRAM read data; valid 1 cycle after rd_address_o (sync read)
//  rd_address_o    out  ADDR_WIDTH  VRAM read address
//  wr_address_o    out  ADDR_WIDTH  RAM write address
//  wr_data_o       out  DATA_WIDTH  RAM write data
//  wr_en_o         out  1           RAM write strobe
//  busy_o          out  1           high in every state except IDLE
//  done_o          out  1           one-cycle pulse: sweep complete
// BEHAVIOUR
//  - Reset (async, any state incl. mid-sweep): state IDLE, counters x=y=addr=0, captured a/c=0;
//    all outputs 0; no done_o for an aborted sweep.
//  - Address = y*ACTIVE_COLUMNS + x; sweep order row-major from 0 to N-1, N = ACTIVE_COLUMNS*ACTIVE_ROWS.
//  - FSM, 4 cycles per cell:
//    IDLE     : outputs 0; ready_i=1 -> FETCH_A with x=y=addr=0.
//    FETCH_A  : rd_address_o = (y==0) ? addr : addr-ACTIVE_COLUMNS -> FETCH_C.
//    FETCH_C  : rd_address_o = addr; capture a = (y==0) ? 0 : pixel_state_i[0] -> FETCH_B.
//    FETCH_B  : rd_address_o = (y==ACTIVE_ROWS-1) ? addr : addr+ACTIVE_COLUMNS; capture c = pixel_state_i[0] -> WRITE.
//    WRITE    : b = (y==ACTIVE_ROWS-1) ? 1 : pixel_state_i[0] (combinational); wr_en_o=1,
//               wr_address_o=addr, wr_data_o = {0.., next}; advance x (wrap to 0, y+1), addr+1;
//               last cell (addr==N-1) -> DONE, else -> FETCH_A.
//    DONE     : done_o=1 one cycle -> IDLE.
//  - Rule: next = c ? b : a  (grain stays if supported or on bottom row, else vacates; empty cell
//    takes the grain above; row 0 never receives). Grain count conserved.
//  - wr_* outputs 0 outside WRITE; rd_address_o 0 in IDLE and DONE.
//  - Latency: ready_i seen in IDLE at cycle 0 -> done_o high at cycle 4N+1.
//  - ready_i ignored while busy (held high -> no restart); high again in IDLE -> new sweep.
//  - Counter widths: x $clog2(ACTIVE_COLUMNS), y $clog2(ACTIVE_ROWS); addr arithmetic ADDR_WIDTH,
//    never produces out-of-range addresses (edge rows clamp to addr).
// STRUCTURE
//  - sand_pkg: state enum (IDLE, FETCH_A, FETCH_C, FETCH_B, WRITE, DONE), CELL_EMPTY/CELL_SAND.
//  - Sub-module sand_cell_rule: combinational (a, c, b) -> next; reused by future diagonal rules.
//  - Top: FSM + x/y/addr counters + a/c capture registers.
// TESTING  (ACTIVE_COLUMNS=4, ACTIVE_ROWS=3, N=12)
//  1. Reset with ready_i=1 held -> all outputs 0, busy_o=0; release -> sweep starts next edge.
//  2. Single grain at addr1 -> writes addr1=0, addr5=1, rest 0; done_o at cycle 49; reads for cell 5: 1,5,9.
//  3. Grain at addr10 (bottom row) -> addr10 written 1; cell 0 reads 0,0,4; cell 10 reads 6,10,10.
//  4. Grains addr0, addr8 -> addr4=1, addr8=1, addr0=0; grains addr4, addr8 -> both stay 1.
//  5. ready_i held high whole sweep -> exactly one done_o, then immediate restart from addr0.
//  6. reset_i pulse during cell 5 WRITE -> outputs 0 same cycle, no done_o; next ready_i restarts at addr0.

Source files
------------

// File: rtl/sand_pkg.sv
// sand_pkg: shared state encoding and cell values for the falling-sand stepper
package sand_pkg;
  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_C, FETCH_B, WRITE, DONE} state_t;
  localparam logic CELL_EMPTY = 1'b0;
  localparam logic CELL_SAND  = 1'b1;
endpackage

// File: rtl/sand_cell_rule.sv
// sand_cell_rule: vertical gravity rule from the cells above (a), current (c) and below (b)
module sand_cell_rule (
  input  logic a,
  input  logic c,
  input  logic b,
  output logic nxt
);
  // A grain stays when supported, an empty cell takes the grain above it
  assign nxt = c ? b : a;
endmodule

// File: rtl/sand_gravity_stepper.sv
// sand_gravity_stepper: sweeps VRAM once, writing the next gravity generation into RAM
module sand_gravity_stepper
  import sand_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] pixel_state_i,
  output logic [ADDR_WIDTH-1:0] rd_address_o,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_en_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int XW = $clog2(ACTIVE_COLUMNS);
  localparam int YW = $clog2(ACTIVE_ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(ACTIVE_COLUMNS-1);
  localparam logic [YW-1:0] Y_LAST = YW'(ACTIVE_ROWS-1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(ACTIVE_COLUMNS*ACTIVE_ROWS-1);
  localparam logic [ADDR_WIDTH-1:0] COLS = ADDR_WIDTH'(ACTIVE_COLUMNS);
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ADDR_WIDTH-1:0] addr;
  logic a, c, b, nxt;
  logic top_row, bottom_row, last;
  assign top_row    = y == '0;
  assign bottom_row = y == Y_LAST;
  assign last       = addr == A_LAST;
  // The floor acts as permanent support for the bottom row
  assign b = bottom_row ? CELL_SAND : pixel_state_i[0];
  sand_cell_rule u_rule (.a(a), .c(c), .b(b), .nxt(nxt));
  // Sequencer: three synchronous reads then one write per cell, row-major
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      addr  <= '0;
      a     <= CELL_EMPTY;
      c     <= CELL_EMPTY;
    end else begin
      case (state)
        IDLE: if (ready_i) begin
          state <= FETCH_A;
          x     <= '0;
          y     <= '0;
          addr  <= '0;
        end
        FETCH_A: state <= FETCH_C;
        FETCH_C: begin
          a     <= top_row ? CELL_EMPTY : pixel_state_i[0];
          state <= FETCH_B;
        end
        FETCH_B: begin
          c     <= pixel_state_i[0];
          state <= WRITE;
        end
        WRITE: begin
          state <= last ? DONE : FETCH_A;
          addr  <= last ? '0 : addr + 1'b1;
          x     <= (x == X_LAST) ? '0 : x + 1'b1;
          y     <= (x == X_LAST) ? (last ? '0 : y + 1'b1) : y;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Edge rows clamp their neighbour reads to the cell itself so addresses stay in range
  always_comb begin
    rd_address_o = state == FETCH_A ? (top_row ? addr : addr - COLS) :
                   state == FETCH_C ? addr :
                   state == FETCH_B ? (bottom_row ? addr : addr + COLS) : '0;
    wr_en_o      = state == WRITE;
    wr_address_o = state == WRITE ? addr : '0;
    wr_data_o    = state == WRITE ? DATA_WIDTH'(nxt) : '0;
    busy_o       = state != IDLE;
    done_o       = state == DONE;
  end
endmodule

// File: tb/tb_sand_gravity_stepper.sv
// tb_sand_gravity_stepper: random and directed sweeps checked against a grain-movement model
module tb_sand_gravity_stepper;
  localparam int C = 4;
  localparam int R = 3;
  localparam int N = C*R;
  localparam int AW = 4;
  logic clk = 0, reset = 1, ready = 1;
  logic [0:0] pixel = '0;
  logic [AW-1:0] rd_a, wr_a;
  logic [0:0] wr_d;
  logic wr_en, busy, done;
  logic [N-1:0] vram = '0, ram = '0;
  logic [AW-1:0] rd_log [4*N+1];
  int checks = 0, errors = 0, done_k = -1, done_n = 0;
  bit chk_en = 0;
  typedef struct {
    logic [AW-1:0] rd;
    bit            rd_chk;
    logic          we;
    logic [AW-1:0] wa;
    logic          wd;
    logic          busy;
    logic          done;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  sand_gravity_stepper #(.ACTIVE_COLUMNS(C), .ACTIVE_ROWS(R)) dut (
    .clk_i(clk), .reset_i(reset), .ready_i(ready), .pixel_state_i(pixel),
    .rd_address_o(rd_a), .wr_address_o(wr_a), .wr_data_o(wr_d),
    .wr_en_o(wr_en), .busy_o(busy), .done_o(done)
  );

  always @(posedge clk) pixel <= vram[rd_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Every grain with an empty cell directly below drops one row; all moves use the old frame
  function automatic logic [N-1:0] model_next(input logic [N-1:0] f);
    logic [N-1:0] r = f;
    for (int i = 0; i < N - C; i++)
      if (f[i] && !f[i+C]) begin
        r[i]   = 1'b0;
        r[i+C] = 1'b1;
      end
    return r;
  endfunction

  function automatic void push_sweep(input logic [N-1:0] f);
    logic [N-1:0] nf = model_next(f);
    for (int i = 0; i < N; i++) begin
      int y = i / C;
      q.push_back('{AW'(y == 0 ? i : i - C), 1, 0, '0, 0, 1, 0});
      q.push_back('{AW'(i), 1, 0, '0, 0, 1, 0});
      q.push_back('{AW'(y == R-1 ? i : i + C), 1, 0, '0, 0, 1, 0});
      q.push_back('{'0, 0, 1, AW'(i), nf[i], 1, 0});
    end
    q.push_back('{'0, 1, 0, '0, 0, 1, 1});
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en) begin
      if (q.size() > 0) e = q.pop_front();
      else e = '{'0, 1, 0, '0, 0, 0, 0};
      if (e.rd_chk) check("rd_address", 32'(rd_a), 32'(e.rd));
      check("wr_en", 32'(wr_en), 32'(e.we));
      check("wr_address", 32'(wr_a), 32'(e.wa));
      check("wr_data", 32'(wr_d), 32'(e.wd));
      check("busy", 32'(busy), 32'(e.busy));
      check("done", 32'(done), 32'(e.done));
    end
  end

  task automatic sweep(input logic [N-1:0] f, input bit hold);
    vram = f;
    ram = '0;
    done_k = -1;
    done_n = 0;
    push_sweep(f);
    ready = 1;
    for (int k = 1; k <= 4*N+1; k++) begin
      @(negedge clk);
      rd_log[k-1] = rd_a;
      if (wr_en) ram[wr_a] = wr_d[0];
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1 && !hold) ready = 0;
    end
    #1;
    check("frame", 32'(ram), 32'(model_next(f)));
    check("grains", 32'($countones(ram)), 32'($countones(f)));
    check("done_cycle", 32'(done_k), 32'(4*N+1));
    check("done_count", 32'(done_n), 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] f;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd", 32'(rd_a), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 0;
    chk_en = 1;
    sweep(12'h002, 0);
    check("t2_ram", 32'(ram), 32'h020);
    check("t2_done_at_49", 32'(done_k), 32'd49);
    check("t2_rd_a5", 32'(rd_log[20]), 32'd1);
    check("t2_rd_c5", 32'(rd_log[21]), 32'd5);
    check("t2_rd_b5", 32'(rd_log[22]), 32'd9);
    sweep(12'h400, 0);
    check("t3_ram", 32'(ram), 32'h400);
    check("t3_rd_a0", 32'(rd_log[0]), 32'd0);
    check("t3_rd_c0", 32'(rd_log[1]), 32'd0);
    check("t3_rd_b0", 32'(rd_log[2]), 32'd4);
    check("t3_rd_a10", 32'(rd_log[40]), 32'd6);
    check("t3_rd_c10", 32'(rd_log[41]), 32'd10);
    check("t3_rd_b10", 32'(rd_log[42]), 32'd10);
    sweep(12'h101, 0);
    check("t4a_ram", 32'(ram), 32'h110);
    sweep(12'h110, 0);
    check("t4b_ram", 32'(ram), 32'h110);
    f = 12'($urandom());
    sweep(f, 1);
    sweep(f, 0);
    check("t5_restart_addr0", 32'(rd_log[0]), 32'd0);
    f = 12'($urandom());
    vram = f;
    push_sweep(f);
    ready = 1;
    @(negedge clk);
    ready = 0;
    repeat (23) @(negedge clk);
    #1;
    reset = 1;
    q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_rd", 32'(rd_a), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    reset = 0;
    repeat (8) @(negedge clk);
    #1;
    for (int n = 0; n < 6; n++) sweep(12'($urandom()), 0);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
